dll_discriminator: RTL and testbench

DLL_DISCRIMINATOR -- requirements
Module: dll_discriminator

---
 rtl/dll_discriminator.sv | 209 ++++++++++++++++++++
 tb/tb_dll_discriminator.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dll_discriminator.sv
// -----------------------------------------------------------------------------
// dll_discriminator
//
// Normalised early-minus-late code discriminator for a DLL tracking loop.
// From one set of early/prompt/late correlator powers it produces
// (E-L)/(E+L) as a signed fixed-point value with FRAC_BITS fractional bits.
// The division is a restoring shift-and-subtract divider that produces one
// quotient bit per cycle. The block also keeps a code-lock indicator that is
// raised after LOCK_COUNT consecutive results in which prompt beats both
// early and late.
//
// State table
//   state  | meaning
//   IDLE   | waiting for an accepted input (i_i2q2_valid && i_track_en)
//   LOAD   | form |E-L|, sign and E+L from the latched powers
//   DIV    | FRAC_BITS+1 restoring-division steps, MSB (weight 1.0) first
//   DONE   | register result, div_zero and lock; pulse o_disc_valid next
//
// Ports
//   i_clk            clock, all state changes on the rising edge
//   i_global_reset   asynchronous active-high reset
//   i_track_en       enables acceptance of new inputs in IDLE
//   i_i2q2_valid     one-cycle pulse qualifying the three power inputs
//   i_i2q2_early     early power  E (unsigned)
//   i_i2q2_prompt    prompt power P (unsigned)
//   i_i2q2_late      late power   L (unsigned)
//   o_disc           signed (E-L)/(E+L) * 2^FRAC_BITS
//   o_disc_valid     one-cycle pulse when o_disc/o_div_zero/o_lock update
//   o_div_zero       last result had E+L == 0
//   o_lock           code-lock indicator
//   o_overrun        one-cycle pulse when an input was dropped while busy
//   o_busy           high in every state other than IDLE
// -----------------------------------------------------------------------------
module dll_discriminator #(
    parameter int unsigned I2Q2_WIDTH = 32,
    parameter int unsigned FRAC_BITS  = 12,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic                        i_clk,
    input  logic                        i_global_reset,
    input  logic                        i_track_en,
    input  logic                        i_i2q2_valid,
    input  logic [I2Q2_WIDTH-1:0]       i_i2q2_early,
    input  logic [I2Q2_WIDTH-1:0]       i_i2q2_prompt,
    input  logic [I2Q2_WIDTH-1:0]       i_i2q2_late,
    output logic signed [FRAC_BITS+1:0] o_disc,
    output logic                        o_disc_valid,
    output logic                        o_div_zero,
    output logic                        o_lock,
    output logic                        o_overrun,
    output logic                        o_busy
);

    localparam int unsigned W  = I2Q2_WIDTH;
    localparam int unsigned CW = $clog2(FRAC_BITS + 2);
    localparam int unsigned LW = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                        w_accept;

    logic [W-1:0]                r_e;
    logic [W-1:0]                r_p;
    logic [W-1:0]                r_l;
    logic [W+1:0]                r_rem;
    logic [W:0]                  r_den;
    logic [FRAC_BITS:0]          r_quo;
    logic [CW-1:0]               r_cnt;
    logic                        r_sign;
    logic [LW-1:0]               r_lock_cnt;

    logic signed [FRAC_BITS+1:0] r_disc;
    logic                        r_disc_valid;
    logic                        r_div_zero;
    logic                        r_lock;
    logic                        r_overrun;

    logic [W-1:0]                w_num;
    logic [W:0]                  w_den;
    logic                        w_ge;
    logic [W+1:0]                w_rem_sub;
    logic [W+1:0]                w_rem_next;
    logic [FRAC_BITS+1:0]        w_mag;
    logic                        w_qual;
    logic [LW-1:0]               w_lock_next;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge i_clk or posedge i_global_reset) begin
        if (i_global_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_i2q2_valid && i_track_en) w_next = S_LOAD;
            S_LOAD:  w_next = S_DIV;
            S_DIV:   if (r_cnt == CW'(FRAC_BITS)) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy   = (r_state != S_IDLE);
        w_accept = (r_state == S_IDLE) && i_i2q2_valid && i_track_en;
    end

    // ----------------------------------------------------------- datapath
    // |E-L| never exceeds E+L, so the first (weight 1.0) quotient bit is set
    // only when one of E/L is zero, and the magnitude tops out at 2^FRAC_BITS.
    assign w_num = (r_l > r_e) ? (r_l - r_e) : (r_e - r_l);
    assign w_den = {1'b0, r_e} + {1'b0, r_l};

    // Remainder stays below 2*den after the shift, hence the two extra bits.
    assign w_ge       = (r_rem >= {1'b0, r_den});
    assign w_rem_sub  = w_ge ? (r_rem - {1'b0, r_den}) : r_rem;
    assign w_rem_next = w_rem_sub << 1;

    assign w_mag  = {1'b0, r_quo};
    assign w_qual = (r_p > r_e) && (r_p > r_l) && (r_den != '0);

    always_comb begin
        w_lock_next = r_lock_cnt;
        if (!w_qual) begin
            w_lock_next = '0;
        end else if (r_lock_cnt != LW'(LOCK_COUNT)) begin
            w_lock_next = r_lock_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_global_reset) begin
        if (i_global_reset) begin
            r_e          <= '0;
            r_p          <= '0;
            r_l          <= '0;
            r_rem        <= '0;
            r_den        <= '0;
            r_quo        <= '0;
            r_cnt        <= '0;
            r_sign       <= 1'b0;
            r_lock_cnt   <= '0;
            r_disc       <= '0;
            r_disc_valid <= 1'b0;
            r_div_zero   <= 1'b0;
            r_lock       <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_disc_valid <= 1'b0;
            // Any valid that arrives while not idle is dropped, even with
            // tracking disabled, so the in-flight result is never disturbed.
            r_overrun    <= i_i2q2_valid && (r_state != S_IDLE);

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_e <= i_i2q2_early;
                        r_p <= i_i2q2_prompt;
                        r_l <= i_i2q2_late;
                    end
                end
                S_LOAD: begin
                    r_rem  <= {2'b00, w_num};
                    r_den  <= w_den;
                    r_sign <= (r_l > r_e);
                    r_quo  <= '0;
                    r_cnt  <= '0;
                end
                S_DIV: begin
                    r_quo <= {r_quo[FRAC_BITS-1:0], w_ge};
                    r_rem <= w_rem_next;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_DONE: begin
                    r_disc_valid <= 1'b1;
                    // With E+L == 0 the divider ran on garbage; force zero.
                    if (r_den == '0) begin
                        r_disc     <= '0;
                        r_div_zero <= 1'b1;
                    end else begin
                        r_disc     <= r_sign ? -$signed(w_mag) : $signed(w_mag);
                        r_div_zero <= 1'b0;
                    end
                    r_lock_cnt <= w_lock_next;
                    r_lock     <= (w_lock_next == LW'(LOCK_COUNT));
                end
                default: ;
            endcase
        end
    end

    assign o_disc       = r_disc;
    assign o_disc_valid = r_disc_valid;
    assign o_div_zero   = r_div_zero;
    assign o_lock       = r_lock;
    assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_dll_discriminator.sv
module tb_dll_discriminator;

    localparam int FB   = 12;
    localparam int LOCK = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               track_en = 1'b0;
    logic               valid = 1'b0;
    logic [31:0]        e_in = '0;
    logic [31:0]        p_in = '0;
    logic [31:0]        l_in = '0;
    logic signed [FB+1:0] o_disc;
    logic               o_disc_valid;
    logic               o_div_zero;
    logic               o_lock;
    logic               o_overrun;
    logic               o_busy;

    dll_discriminator dut (
        .i_clk          (clk),
        .i_global_reset (rst),
        .i_track_en     (track_en),
        .i_i2q2_valid   (valid),
        .i_i2q2_early   (e_in),
        .i_i2q2_prompt  (p_in),
        .i_i2q2_late    (l_in),
        .o_disc         (o_disc),
        .o_disc_valid   (o_disc_valid),
        .o_div_zero     (o_div_zero),
        .o_lock         (o_lock),
        .o_overrun      (o_overrun),
        .o_busy         (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint disc;
        logic   dz;
        logic   lock;
        int     due;
    } exp_t;

    exp_t   sb_q[$];
    int     ov_q[$];
    int     cyc = 0;
    int     acc_edge = -100;
    int     lcnt = 0;
    longint hold_disc = 0;
    logic   hold_dz = 1'b0;
    logic   hold_lock = 1'b0;
    int     total = 0;
    int     bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic signed [63:0] got,
                         input logic signed [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference: result = floor(|E-L| * 2^FB / (E+L)), signed by L>E; lock
    // after LOCK consecutive results with P above both E and L.
    task automatic issue(input logic [31:0] e, input logic [31:0] p,
                         input logic [31:0] l, input logic te);
        int     edge_n;
        longint num, den, mag;
        exp_t   x;
        @(negedge clk); #1;
        e_in = e; p_in = p; l_in = l; track_en = te; valid = 1'b1;
        edge_n = cyc + 1;
        if (edge_n > acc_edge && edge_n < acc_edge + 16) begin
            ov_q.push_back(edge_n);
        end else if (te) begin
            acc_edge = edge_n;
            num = (e > l) ? longint'(e) - longint'(l) : longint'(l) - longint'(e);
            den = longint'(e) + longint'(l);
            mag = (den == 0) ? 0 : (num * (longint'(1) << FB)) / den;
            x.disc = (l > e) ? -mag : mag;
            x.dz   = (den == 0);
            if (p > e && p > l && den != 0) lcnt = (lcnt < LOCK) ? lcnt + 1 : LOCK;
            else lcnt = 0;
            x.lock = (lcnt == LOCK);
            x.due  = edge_n + FB + 3;
            sb_q.push_back(x);
        end
        @(negedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk); #2;
        rst = 1'b1;
        sb_q.delete(); ov_q.delete();
        acc_edge = -100; lcnt = 0;
        hold_disc = 0; hold_dz = 1'b0; hold_lock = 1'b0;
        #1;
        check("rst_busy", o_busy, 0);
        check("rst_disc", o_disc, 0);
        check("rst_valid", o_disc_valid, 0);
        check("rst_dz", o_div_zero, 0);
        check("rst_lock", o_lock, 0);
        check("rst_ovr", o_overrun, 0);
        @(negedge clk); #2;
        rst = 1'b0;
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t x;
        logic exp_ov;
        if (!rst) begin
            check("busy", o_busy, (cyc >= acc_edge && cyc <= acc_edge + 14));
            exp_ov = (ov_q.size() > 0) && (ov_q[0] == cyc);
            check("overrun", o_overrun, exp_ov);
            if (exp_ov) void'(ov_q.pop_front());
            if (o_disc_valid) begin
                if (sb_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL spurious_valid: got disc_valid=1 expected none (cycle %0d)", cyc);
                end else begin
                    x = sb_q.pop_front();
                    check("latency", cyc, x.due);
                    check("disc", o_disc, x.disc);
                    check("div_zero", o_div_zero, x.dz);
                    check("lock", o_lock, x.lock);
                    hold_disc = x.disc; hold_dz = x.dz; hold_lock = x.lock;
                end
            end else begin
                check("disc_hold", o_disc, hold_disc);
                check("dz_hold", o_div_zero, hold_dz);
                check("lock_hold", o_lock, hold_lock);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1);
    end

    function automatic logic [31:0] rnd_pow();
        case ($urandom_range(0, 3))
            0: return 32'($urandom_range(0, 3));
            1: return 32'($urandom_range(0, 1000));
            2: return $urandom;
            default: return 32'hFFFF_FFFF - 32'($urandom_range(0, 2));
        endcase
    endfunction

    initial begin
        logic [31:0] e, p, l;
        idle(3);
        do_reset();
        idle(2);

        // Directed values
        issue(300, 500, 100, 1'b1); idle(20);
        issue(100, 0, 300, 1'b1);   idle(20);
        issue(0, 0, 500, 1'b1);     idle(20);
        issue(500, 0, 0, 1'b1);     idle(20);
        issue(1, 0, 2, 1'b1);       idle(20);
        issue(0, 9, 0, 1'b1);       idle(20);
        issue(7, 0, 7, 1'b1);       idle(20);

        // Overrun: second valid 5 edges after the first
        issue(300, 10, 100, 1'b1); idle(3);
        issue(5, 5, 900, 1'b1);    idle(20);
        // Busy-time valid with tracking off still counts as overrun
        issue(40, 1, 20, 1'b1);    idle(2);
        issue(1, 1, 1, 1'b0);      idle(20);
        // Tracking off in IDLE: ignored, no busy, no overrun
        issue(100, 200, 50, 1'b0); idle(20);
        // Tracking dropped mid-computation does not abort
        issue(123, 0, 45, 1'b1);   idle(4);
        @(negedge clk); #1 track_en = 1'b0;
        idle(20);

        // Lock: clear, four qualifying, then one with P<E
        issue(300, 0, 100, 1'b1); idle(20);
        for (int i = 0; i < 4; i++) begin
            issue(300 + 32'(i), 900, 100, 1'b1); idle(20);
        end
        issue(300, 100, 100, 1'b1); idle(20);

        // Reset six cycles into DIV, then a fresh input
        issue(300, 500, 100, 1'b1); idle(7);
        #1 check("busy_pre_rst", o_busy, 1);
        do_reset();
        idle(2);
        issue(100, 500, 300, 1'b1); idle(20);

        // Randomised traffic
        for (int n = 0; n < 80; n++) begin
            e = rnd_pow(); l = rnd_pow(); p = rnd_pow();
            if ($urandom_range(0, 7) == 0) l = e;
            if ($urandom_range(0, 5) == 0) p = ((e > l) ? e : l) + 32'd1;
            if (p == 32'd0 && $urandom_range(0, 1) == 1) p = 32'd1;
            issue(e, p, l, ($urandom_range(0, 9) != 0));
            idle($urandom_range(0, 18));
        end

        // Drain with a bounded wait
        for (int k = 0; k < 60 && (sb_q.size() != 0 || ov_q.size() != 0); k++)
            @(negedge clk);
        check("drain_results", sb_q.size(), 0);
        check("drain_overruns", ov_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
